// File: rtl/irf_window_swap_ctl_if.sv
// Bundle of request and strobe signals between the per-thread swap requesters
// and the IRF window-swap controller.
//   master : requester side, drives req_vld / req_old_cwp / req_new_cwp / stall
//   slave  : controller side, drives req_ack, IRF save/restore strobes and
//            addresses, thread select, swap_busy, swap_done / swap_done_tid
interface irf_window_swap_ctl_if #(
  parameter int NTHR = 4,
  parameter int CWPW = 3,
  parameter int TIDW = $clog2(NTHR)
) ();
  logic [NTHR-1:0]      req_vld;
  logic [NTHR*CWPW-1:0] req_old_cwp;
  logic [NTHR*CWPW-1:0] req_new_cwp;
  logic                 stall;
  logic [NTHR-1:0]      req_ack;
  logic [TIDW-1:0]      irf_thr_sel;
  logic                 irf_save;
  logic [CWPW-1:0]      irf_save_addr;
  logic                 irf_restore;
  logic [CWPW-1:0]      irf_restore_addr;
  logic                 swap_busy;
  logic                 swap_done;
  logic [TIDW-1:0]      swap_done_tid;

  modport master (
    output req_vld, req_old_cwp, req_new_cwp, stall,
    input  req_ack, irf_thr_sel, irf_save, irf_save_addr, irf_restore,
           irf_restore_addr, swap_busy, swap_done, swap_done_tid
  );

  modport slave (
    input  req_vld, req_old_cwp, req_new_cwp, stall,
    output req_ack, irf_thr_sel, irf_save, irf_save_addr, irf_restore,
           irf_restore_addr, swap_busy, swap_done, swap_done_tid
  );
endinterface

// File: rtl/irf_window_swap_ctl.sv
// IRF window-swap sequencer. Round-robin arbitrates per-thread SAVE/RESTORE
// window swap requests and drives the shared register-cell strobes, one swap
// at a time.
// Ports:
//   clk    core clock, posedge
//   reset  synchronous, active-high; drops any swap in flight
//   bus    irf_window_swap_ctl_if.slave: requests in, ack/strobes/status out
// Every output is a flop. The FSM state is one cycle ahead of the outputs it
// produces: while state is SAVE (grant cycle G) it loads the save strobe that
// appears in G+1, and so on.
module irf_window_swap_ctl #(
  parameter int NTHR = 4,
  parameter int CWPW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  irf_window_swap_ctl_if.slave  bus
);
  localparam int TIDW = $clog2(NTHR);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_RESTORE, S_DONE, S_SKIP
  } state_e;

  state_e          state_q, state_d;
  logic [TIDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TIDW-1:0] tid_q, tid_d;
  logic [CWPW-1:0] old_cwp_q, old_cwp_d;
  logic [CWPW-1:0] new_cwp_q, new_cwp_d;

  logic [NTHR-1:0] req_ack_q, req_ack_d;
  logic [TIDW-1:0] thr_sel_q, thr_sel_d;
  logic            save_q, save_d;
  logic [CWPW-1:0] save_addr_q, save_addr_d;
  logic            restore_q, restore_d;
  logic [CWPW-1:0] restore_addr_q, restore_addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TIDW-1:0] done_tid_q, done_tid_d;

  logic            found;
  int              idx;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    tid_d          = tid_q;
    old_cwp_d      = old_cwp_q;
    new_cwp_d      = new_cwp_q;
    req_ack_d      = '0;
    thr_sel_d      = thr_sel_q;
    save_d         = 1'b0;
    save_addr_d    = save_addr_q;
    restore_d      = 1'b0;
    restore_addr_d = restore_addr_q;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    done_tid_d     = done_tid_q;
    found          = 1'b0;
    idx            = 0;

    case (state_q)
      S_IDLE: begin
        // Scan from rr_ptr upward with wrap; the first live request wins.
        if (!bus.stall) begin
          for (int i = 0; i < NTHR; i++) begin
            if (!found && bus.req_vld[(int'(rr_ptr_q) + i) % NTHR]) begin
              found          = 1'b1;
              idx            = (int'(rr_ptr_q) + i) % NTHR;
              tid_d          = TIDW'(idx);
              old_cwp_d      = bus.req_old_cwp[idx*CWPW +: CWPW];
              new_cwp_d      = bus.req_new_cwp[idx*CWPW +: CWPW];
              req_ack_d[idx] = 1'b1;
              rr_ptr_d       = TIDW'((idx + 1) % NTHR);
              // Same window in and out: nothing to move, finish next cycle.
              state_d = (old_cwp_d == new_cwp_d) ? S_SKIP : S_SAVE;
            end
          end
        end
      end
      S_SAVE: begin
        save_d      = 1'b1;
        save_addr_d = old_cwp_q;
        thr_sel_d   = tid_q;
        busy_d      = 1'b1;
        state_d     = S_RESTORE;
      end
      S_RESTORE: begin
        restore_d      = 1'b1;
        restore_addr_d = new_cwp_q;
        thr_sel_d      = tid_q;
        busy_d         = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE, S_SKIP: begin
        done_d     = 1'b1;
        done_tid_d = tid_q;
        busy_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      req_ack_q      <= '0;
      thr_sel_q      <= '0;
      save_q         <= 1'b0;
      save_addr_q    <= '0;
      restore_q      <= 1'b0;
      restore_addr_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      done_tid_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      req_ack_q      <= req_ack_d;
      thr_sel_q      <= thr_sel_d;
      save_q         <= save_d;
      save_addr_q    <= save_addr_d;
      restore_q      <= restore_d;
      restore_addr_q <= restore_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      done_tid_q     <= done_tid_d;
    end
  end

  // Latched request payload; only read in states entered through a grant.
  always_ff @(posedge clk) begin
    tid_q     <= tid_d;
    old_cwp_q <= old_cwp_d;
    new_cwp_q <= new_cwp_d;
  end

  assign bus.req_ack          = req_ack_q;
  assign bus.irf_thr_sel      = thr_sel_q;
  assign bus.irf_save         = save_q;
  assign bus.irf_save_addr    = save_addr_q;
  assign bus.irf_restore      = restore_q;
  assign bus.irf_restore_addr = restore_addr_q;
  assign bus.swap_busy        = busy_q;
  assign bus.swap_done        = done_q;
  assign bus.swap_done_tid    = done_tid_q;
endmodule
